// File: rtl/fw_msg_pkg.sv
// Firmware message interface: register map, message types and FSM states.
package fw_msg_pkg;

    localparam logic [31:0] OFS_CONTROL    = 32'h00;
    localparam logic [31:0] OFS_REPORT     = 32'h04;
    localparam logic [31:0] OFS_WARNING    = 32'h08;
    localparam logic [31:0] OFS_ERROR      = 32'h0C;
    localparam logic [31:0] OFS_MEASURED   = 32'h10;
    localparam logic [31:0] OFS_EXPECTED   = 32'h14;
    localparam logic [31:0] OFS_MEMORY     = 32'h18;
    localparam logic [31:0] OFS_MEMORY_END = 32'h58;

    typedef enum logic [1:0] {
        MSG_REPORT  = 2'd0,
        MSG_WARNING = 2'd1,
        MSG_ERROR   = 2'd2,
        MSG_COMPARE = 2'd3
    } msg_type_e;

    typedef enum logic [2:0] {
        IDLE,
        STR_WAIT,
        STR_WR,
        NUL_WR,
        VAL_A_WR,
        VAL_B_WR,
        CTRL_WR,
        DONE
    } state_e;

    function automatic logic [31:0] val_a_ofs(input msg_type_e t);
        case (t)
            MSG_REPORT:  return OFS_REPORT;
            MSG_WARNING: return OFS_WARNING;
            MSG_ERROR:   return OFS_ERROR;
            default:     return OFS_MEASURED;
        endcase
    endfunction

    function automatic logic [31:0] mem_ofs(input logic [5:0] i);
        return OFS_MEMORY + {26'd0, i[5:2], 2'b00};
    endfunction

    // Byte 0 of each word sits in the most significant lane.
    function automatic logic [3:0] lane_sel(input logic [1:0] lane);
        return 4'h8 >> lane;
    endfunction

endpackage

// File: rtl/fw_msg_wb_single.sv
// One classic Wishbone write: launched by a req pulse, ended by ack, err/rty
// or an access timeout.
module fw_msg_wb_single
    import fw_msg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  sel,
    output logic        done,
    output logic        err,
    output logic        timeout,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    logic [7:0] cnt;
    logic       fail;
    logic       last_cyc;

    assign fail     = wb_err_i | wb_rty_i;
    assign last_cyc = (cnt == 8'(TIMEOUT - 1));
    assign err      = wb_cyc_o & fail;
    assign done     = wb_cyc_o & ~fail & wb_ack_i;
    assign timeout  = wb_cyc_o & ~fail & ~wb_ack_i & last_cyc;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt      <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
        end else if (wb_cyc_o) begin
            if (err | done | timeout) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else if (req) begin
            cnt      <= '0;
            wb_adr_o <= addr;
            wb_dat_o <= data;
            wb_sel_o <= sel;
            wb_we_o  <= 1'b1;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
        end
    end

endmodule

// File: rtl/fw_msg_wb_master.sv
// Sequences string bytes, terminator, value registers and the control word
// of one firmware message onto Wishbone.
module fw_msg_wb_master
    import fw_msg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic [1:0]  msg_type_i,
    input  logic [31:0] value_a_i,
    input  logic [31:0] value_b_i,
    input  logic        str_valid_i,
    input  logic [7:0]  str_data_i,
    input  logic        str_last_i,
    output logic        str_ready_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        bus_err_o,
    output logic        timeout_o,
    output logic        trunc_o
);

    state_e      state;
    msg_type_e   mtype;
    logic [31:0] val_a;
    logic [31:0] val_b;
    logic [5:0]  idx;
    logic [5:0]  idx_nx;
    logic        last_q;
    logic        req;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_sel;
    logic        wr_done;
    logic        wr_err;
    logic        wr_tmo;
    logic        unused_ok;

    assign unused_ok = ^wb_dat_i;
    assign idx_nx    = (idx == 6'd63) ? idx : idx + 6'd1;

    fw_msg_wb_single #(.TIMEOUT(TIMEOUT)) u_single (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req      (req),
        .addr     (w_addr),
        .data     (w_data),
        .sel      (w_sel),
        .done     (wr_done),
        .err      (wr_err),
        .timeout  (wr_tmo),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_cti_o (wb_cti_o),
        .wb_bte_o (wb_bte_o),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state       <= IDLE;
            mtype       <= MSG_REPORT;
            val_a       <= '0;
            val_b       <= '0;
            idx         <= '0;
            last_q      <= 1'b0;
            req         <= 1'b0;
            w_addr      <= '0;
            w_data      <= '0;
            w_sel       <= '0;
            str_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            bus_err_o   <= 1'b0;
            timeout_o   <= 1'b0;
            trunc_o     <= 1'b0;
        end else begin
            req <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mtype       <= msg_type_e'(msg_type_i);
                        val_a       <= value_a_i;
                        val_b       <= value_b_i;
                        idx         <= '0;
                        bus_err_o   <= 1'b0;
                        timeout_o   <= 1'b0;
                        trunc_o     <= 1'b0;
                        busy_o      <= 1'b1;
                        str_ready_o <= 1'b1;
                        state       <= STR_WAIT;
                    end
                end
                STR_WAIT: begin
                    if (str_valid_i) begin
                        last_q <= str_last_i;
                        if (idx != 6'd63) begin
                            str_ready_o <= 1'b0;
                            state       <= STR_WR;
                            req         <= 1'b1;
                            w_addr      <= BASE_ADDR + mem_ofs(idx);
                            w_data      <= {4{str_data_i}};
                            w_sel       <= lane_sel(idx[1:0]);
                        end else begin
                            // Buffer full: drop the byte, keep draining.
                            trunc_o <= 1'b1;
                            if (str_last_i) begin
                                str_ready_o <= 1'b0;
                                state       <= NUL_WR;
                                req         <= 1'b1;
                                w_addr      <= BASE_ADDR + mem_ofs(idx);
                                w_data      <= '0;
                                w_sel       <= lane_sel(idx[1:0]);
                            end
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    if (wr_err) begin
                        bus_err_o <= 1'b1;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end else if (wr_tmo) begin
                        timeout_o <= 1'b1;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end else if (wr_done) begin
                        case (state)
                            STR_WR: begin
                                idx <= idx_nx;
                                if (last_q) begin
                                    state  <= NUL_WR;
                                    req    <= 1'b1;
                                    w_addr <= BASE_ADDR + mem_ofs(idx_nx);
                                    w_data <= '0;
                                    w_sel  <= lane_sel(idx_nx[1:0]);
                                end else begin
                                    state       <= STR_WAIT;
                                    str_ready_o <= 1'b1;
                                end
                            end
                            NUL_WR: begin
                                state  <= VAL_A_WR;
                                req    <= 1'b1;
                                w_addr <= BASE_ADDR + val_a_ofs(mtype);
                                w_data <= val_a;
                                w_sel  <= 4'hF;
                            end
                            VAL_A_WR: begin
                                req   <= 1'b1;
                                w_sel <= 4'hF;
                                if (mtype == MSG_COMPARE) begin
                                    state  <= VAL_B_WR;
                                    w_addr <= BASE_ADDR + OFS_EXPECTED;
                                    w_data <= val_b;
                                end else begin
                                    state  <= CTRL_WR;
                                    w_addr <= BASE_ADDR + OFS_CONTROL;
                                    w_data <= 32'h1 << mtype;
                                end
                            end
                            VAL_B_WR: begin
                                state  <= CTRL_WR;
                                req    <= 1'b1;
                                w_addr <= BASE_ADDR + OFS_CONTROL;
                                w_data <= 32'h1 << mtype;
                                w_sel  <= 4'hF;
                            end
                            CTRL_WR: begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fw_msg_wb_master.sv
// Directed and randomized messages against a transaction-level model of
// the expected Wishbone write sequence.
module tb_fw_msg_wb_master;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  msg_type_i = '0;
    logic [31:0] value_a_i = '0;
    logic [31:0] value_b_i = '0;
    logic        str_valid_i = 1'b0;
    logic [7:0]  str_data_i = '0;
    logic        str_last_i = 1'b0;
    logic        str_ready_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic        busy_o, done_o, bus_err_o, timeout_o, trunc_o;

    always #5 clk = ~clk;

    fw_msg_wb_master #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start_i),
        .msg_type_i(msg_type_i), .value_a_i(value_a_i), .value_b_i(value_b_i),
        .str_valid_i(str_valid_i), .str_data_i(str_data_i),
        .str_last_i(str_last_i), .str_ready_o(str_ready_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .busy_o(busy_o), .done_o(done_o), .bus_err_o(bus_err_o),
        .timeout_o(timeout_o), .trunc_o(trunc_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder state and write log
    int          fault_at = -1;
    bit          never = 1'b0;
    int          delay = 0;
    int          wait_n = 0;
    int          wr_count = 0;
    bit          in_acc = 1'b0;
    int          cyc_hi = 0;
    int          cyc_lo = 0;
    int          stab_bad = 0;
    int          done_cnt = 0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [3:0]  log_sel[$];
    int          log_gap[$];

    initial begin
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
            wb_dat_i = $urandom;
            if (done_o) done_cnt++;
            if (!wb_cyc_o) begin
                in_acc = 1'b0;
                cyc_lo++;
            end else begin
                cyc_hi++;
                if (!in_acc) begin
                    in_acc = 1'b1;
                    wait_n = 0;
                    log_adr.push_back(wb_adr_o);
                    log_dat.push_back(wb_dat_o);
                    log_sel.push_back(wb_sel_o);
                    log_gap.push_back(cyc_lo);
                    cyc_lo = 0;
                end else begin
                    wait_n++;
                    if (wb_adr_o !== log_adr[$] || wb_dat_o !== log_dat[$] ||
                        wb_sel_o !== log_sel[$])
                        stab_bad++;
                end
                if (!wb_stb_o || !wb_we_o || wb_cti_o != 3'b000 ||
                    wb_bte_o != 2'b00)
                    stab_bad++;
                if (!never && wait_n >= delay) begin
                    if (fault_at == wr_count) begin
                        if ($urandom_range(0, 1) == 1) wb_err_i = 1'b1;
                        else wb_rty_i = 1'b1;
                        wb_ack_i = 1'($urandom_range(0, 1));
                    end else begin
                        wb_ack_i = 1'b1;
                    end
                    wr_count++;
                    delay = $urandom_range(0, 3);
                end
            end
        end
    end

    logic [7:0]  msg_bytes[128];
    logic [31:0] ea[$];
    logic [31:0] ed[$];
    logic [3:0]  es[$];
    bit          got_done;
    logic        f_berr, f_tmo, f_trunc;

    task automatic clear_log();
        log_adr.delete(); log_dat.delete(); log_sel.delete(); log_gap.delete();
        wr_count = 0;
        cyc_hi = 0;
        cyc_lo = 0;
        stab_bad = 0;
    endtask

    // Expected write list straight from the register map
    task automatic build_exp(input int ty, input logic [31:0] a,
                             input logic [31:0] b, input int n);
        int k;
        int ofs[4];
        ofs = '{4, 8, 12, 16};
        ea.delete(); ed.delete(); es.delete();
        k = (n < 63) ? n : 63;
        for (int i = 0; i < k; i++) begin
            ea.push_back(BASE + 32'(24 + 4 * (i / 4)));
            ed.push_back(32'(msg_bytes[i]) * 32'h0101_0101);
            es.push_back(4'(8 >> (i % 4)));
        end
        ea.push_back(BASE + 32'(24 + 4 * (k / 4)));
        ed.push_back(32'h0);
        es.push_back(4'(8 >> (k % 4)));
        ea.push_back(BASE + 32'(ofs[ty]));
        ed.push_back(a);
        es.push_back(4'hF);
        if (ty == 3) begin
            ea.push_back(BASE + 32'h14);
            ed.push_back(b);
            es.push_back(4'hF);
        end
        ea.push_back(BASE);
        ed.push_back(32'(1 << ty));
        es.push_back(4'hF);
    endtask

    task automatic send(input int ty, input logic [31:0] a,
                        input logic [31:0] b, input int n, input bit stop_vala);
        int i;
        i = 0;
        got_done = 1'b0;
        clear_log();
        @(negedge clk);
        start_i = 1'b1;
        msg_type_i = 2'(ty);
        value_a_i = a;
        value_b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (done_o) begin
                got_done = 1'b1;
                f_berr = bus_err_o;
                f_tmo = timeout_o;
                f_trunc = trunc_o;
                break;
            end
            if (stop_vala && wb_cyc_o && wb_adr_o == BASE + 32'h4) break;
            // Start and payload are scrambled while busy; both must be ignored.
            start_i = ($urandom_range(0, 7) == 0);
            msg_type_i = 2'($urandom);
            value_a_i = $urandom;
            value_b_i = $urandom;
            if (str_ready_o && i < n && $urandom_range(0, 3) != 0) begin
                str_valid_i = 1'b1;
                str_data_i = msg_bytes[i];
                str_last_i = (i == n - 1);
                i++;
            end else begin
                str_valid_i = 1'b0;
                str_data_i = 8'($urandom);
                str_last_i = 1'($urandom);
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        str_valid_i = 1'b0;
    endtask

    task automatic run_msg(input string tag, input int ty,
                           input logic [31:0] a, input logic [31:0] b,
                           input int n);
        int nexp, ncmp, k;
        send(ty, a, b, n, 1'b0);
        build_exp(ty, a, b, n);
        nexp = ea.size();
        if (fault_at >= 0 && fault_at + 1 < nexp) nexp = fault_at + 1;
        if (never) nexp = 1;
        k = (n < 63) ? n : 63;
        chk({tag, ".done"}, 32'(got_done), 1);
        chk({tag, ".nwr"}, log_adr.size(), nexp);
        ncmp = (log_adr.size() < nexp) ? log_adr.size() : nexp;
        for (int j = 0; j < ncmp; j++) begin
            chk($sformatf("%s.adr%0d", tag, j), log_adr[j], ea[j]);
            chk($sformatf("%s.dat%0d", tag, j), log_dat[j], ed[j]);
            chk($sformatf("%s.sel%0d", tag, j), 32'(log_sel[j]), 32'(es[j]));
            if (j > k) chk($sformatf("%s.gap%0d", tag, j), log_gap[j], 1);
        end
        chk({tag, ".bus_err"}, 32'(f_berr), 32'(fault_at >= 0));
        chk({tag, ".timeout"}, 32'(f_tmo), 32'(never));
        chk({tag, ".trunc"}, 32'(f_trunc),
            32'(n > 63 && !never && (fault_at < 0 || fault_at >= 63)));
        chk({tag, ".stable"}, stab_bad, 0);
        if (never) chk({tag, ".cyc_cycles"}, cyc_hi, TMO);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done_o), 0);
        chk({tag, ".idle"}, 32'({busy_o, wb_cyc_o}), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".adr"}, wb_adr_o, 0);
        chk({tag, ".dat"}, wb_dat_o, 0);
        chk({tag, ".ctl"}, 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
                                wb_cti_o, wb_bte_o, str_ready_o}), 0);
        chk({tag, ".stat"}, 32'({busy_o, done_o, bus_err_o, timeout_o,
                                 trunc_o}), 0);
    endtask

    initial begin
        int snap;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        msg_bytes[0] = "H";
        msg_bytes[1] = "I";
        run_msg("hi", 0, 32'h1234, 32'h0, 2);

        msg_bytes[0] = 8'h5A;
        run_msg("cmp", 3, 32'd5, 32'd7, 1);

        for (int j = 0; j < 128; j++) msg_bytes[j] = 8'($urandom);
        run_msg("long70", 1, $urandom, $urandom, 70);

        fault_at = 2;
        run_msg("err3", 2, $urandom, $urandom, 5);
        fault_at = -1;

        never = 1'b1;
        run_msg("noack", 0, $urandom, $urandom, 3);
        never = 1'b0;

        for (int r = 0; r < 6; r++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 68)
                                            : $urandom_range(1, 9);
            for (int j = 0; j < 128; j++) msg_bytes[j] = 8'($urandom);
            run_msg($sformatf("rnd%0d", r), $urandom_range(0, 3),
                    $urandom, $urandom, n);
        end

        send(0, 32'hCAFE, 32'h0, 2, 1'b1);
        chk("rst_mid.at_vala", 32'(wb_cyc_o && wb_adr_o == BASE + 32'h4), 1);
        snap = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        repeat (3) @(negedge clk);
        chk("rst_mid.no_done", done_cnt, snap);
        rst_n = 1'b1;
        for (int j = 0; j < 128; j++) msg_bytes[j] = 8'($urandom);
        run_msg("after_rst", 3, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fw_msg_wb_master.md
FW_MSG_WB_MASTER -- requirements
Module: fw_msg_wb_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, meaning word-aligned base address of the firmware-interface responder.
REQ-002 Parameter TIMEOUT, default 16, meaning the number of cycles waited for ack/err before a write is abandoned (range 2..255).
REQ-003 wb_clk_i  in  1  is the single clock; all logic is on its rising edge.
REQ-004 wb_rst_i  in  1  is the reset, asynchronous and active-low.
REQ-005 start_i  in  1  is a one-cycle message request, sampled in IDLE only.
REQ-006 msg_type_i  in  2  selects the message: 0 report, 1 warning, 2 error, 3 compare; it is captured at start.
REQ-007 value_a_i / value_b_i  in  32 each  carry the register payloads, captured at start: value_a is report/warning/error/measured; value_b is expected.
REQ-008 str_valid_i, str_data_i[7:0], str_last_i  in  1/8/1  form the string byte stream.
REQ-009 str_ready_o  out  1  accepts one string byte when high together with str_valid_i.
REQ-010 wb_adr_o[31:0], wb_dat_o[31:0], wb_sel_o[3:0], wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o[2:0], wb_bte_o[1:0]  out  form the Wishbone initiator outputs.
REQ-011 wb_dat_i[31:0], wb_ack_i, wb_err_i, wb_rty_i  in  form the Wishbone responses; wb_rty_i is treated as wb_err_i.
REQ-012 busy_o, done_o, bus_err_o, timeout_o, trunc_o  out  1 each are status outputs: done_o is a one-cycle pulse, and the other flags are valid while done_o is high.

Function
REQ-013 The block SHALL use states IDLE, STR_WAIT, STR_WR, NUL_WR, VAL_A_WR, VAL_B_WR, CTRL_WR and DONE.
REQ-014 On start_i in IDLE, the block SHALL capture its inputs, clear the byte counter idx (6 bit) and the status flags, and move to STR_WAIT; busy_o is high in every state except IDLE.
REQ-015 STR_WAIT: str_ready_o is high; an accepted byte is registered. If idx<63 the block moves to STR_WR; otherwise the byte is discarded, trunc_o is set, and the block stays in STR_WAIT unless the byte is last.
REQ-016 An accepted last byte SHALL lead to NUL_WR after its STR_WR, or directly to NUL_WR when that byte was discarded.
REQ-017 Byte write: adr = BASE_ADDR+0x18+{idx[5:2],2'b00}, sel = 4'h8>>idx[1:0], dat = byte replicated on all four lanes, we=1.
REQ-018 After each acknowledged byte write, idx SHALL increment by 1 without wrap (maximum 63).
REQ-019 NUL_WR SHALL write 8'h00 at index idx using the same addressing as REQ-017.
REQ-020 VAL_A_WR SHALL write value_a with sel 4'hF to offset 0x04, 0x08 or 0x0C for types 0, 1 and 2, or to 0x10 (measured) for type 3.
REQ-021 VAL_B_WR SHALL occur for type 3 only and SHALL write value_b to 0x14.
REQ-022 CTRL_WR SHALL write 32'h1<<msg_type with sel 4'hF to offset 0x00, and then move to DONE.
REQ-023 Every write SHALL be a classic single cycle (cti=3'b000, bte=2'b00). cyc and stb rise together and hold all outputs stable until ack or err, then drop in the next cycle. There is one cycle of idle bus between accesses, so a new access never starts in the cycle after ack.
REQ-024 When ack and err arrive in the same cycle, err SHALL win.
REQ-025 On err, the block SHALL set bus_err_o and go to DONE, skipping all remaining writes.
REQ-026 A per-access counter SHALL reach TIMEOUT with no response, then the block drops cyc/stb, sets timeout_o, and goes to DONE.
REQ-027 DONE SHALL last exactly one cycle with done_o=1 and return to IDLE; start_i is ignored whenever the block is not in IDLE.
REQ-028 The block SHALL never drive wb_we_o low (it is a write-only initiator), and wb_dat_i SHALL be ignored.

Reset
REQ-029 Asserting wb_rst_i SHALL immediately force IDLE, and all outputs SHALL be 0: cyc, stb, we, adr, dat, sel, cti, bte, busy, done and all flags.
REQ-030 Reset mid-transfer SHALL abandon the access without completing it, with no pulse on done_o.
REQ-031 Reset deassertion is synchronised externally; the first start_i is honoured on the edge after deassertion.

Structure
REQ-032 A shared package fw_msg_pkg SHALL hold the register offsets (CONTROL 0x00, REPORT 0x04, WARNING 0x08, ERROR 0x0C, MEASURED 0x10, EXPECTED 0x14, MEMORY 0x18, MEMORY_END 0x58), the message-type encodings, and the state enumeration.
REQ-033 One sub-module, fw_msg_wb_single, SHALL own a single Wishbone write (req/addr/data/sel in; done/err/timeout out; timeout counter inside), and the FSM sequences it.

Verification
REQ-034 Report "HI" with value 0x1234: writes SHALL be adr 0x18 sel 8 'H', adr 0x18 sel 4 'I', adr 0x18 sel 2 NUL, adr 0x04 0x1234, then adr 0x00 0x1; done_o is high with all flags clear.
REQ-035 Compare with measured 5, expected 7, and a 1-byte string: writes SHALL go to 0x10 = 5, then 0x14 = 7, then 0x00 = 0x8.
REQ-036 A 70-byte string: 63 byte writes (last at adr 0x54 sel 2), NUL at adr 0x54 sel 1, and trunc_o=1 at done.
REQ-037 err asserted on the third byte write: bus_err_o=1, and there is no register or control write afterwards.
REQ-038 A responder that never acks with TIMEOUT=16: cyc drops after 16 cycles and timeout_o=1.
REQ-039 Reset asserted during VAL_A_WR: outputs go to 0 asynchronously; a new message after release completes normally.
